// File: rtl/alex_sched_pkg.sv
// Shared types and constants for the ALEX filter-board write scheduler.
package alex_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPreGuard,
        StShift,
        StLatch,
        StPostGuard
    } alex_state_e;

    localparam int unsigned ALEX_WORD_BITS = 16;
    localparam int unsigned ALEX_LATCH_BIT = 16;

    localparam int unsigned SCLK  = 0;
    localparam int unsigned SDATA = 1;
    localparam int unsigned TXL   = 2;
    localparam int unsigned RXL   = 3;

    // Width of a down-counter holding values 0..n, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n == 0) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/alex_bit_timer.sv
// SCLK half-period timer: ticks on the last cycle of each CLK_DIV-cycle phase.
// Held at reload (phase 0) while disabled, so every enable starts a fresh low phase.
module alex_bit_timer
    import alex_sched_pkg::*;
#(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic enable,
    output logic phase_tick,
    output logic sclk_phase
);

    localparam int unsigned CW = cnt_width(CLK_DIV - 1);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic          phase_q;

    always_ff @(posedge aclk) begin
        if (!aresetn || !enable) begin
            cnt_q   <= RELOAD;
            phase_q <= 1'b0;
        end else if (cnt_q == '0) begin
            cnt_q   <= RELOAD;
            phase_q <= ~phase_q;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign phase_tick = enable && (cnt_q == '0);
    assign sclk_phase = phase_q;

endmodule

// File: rtl/axis_alex_scheduler.sv
// AXI4-Stream to ALEX serial writer sharing the I2S GPIO pins via alex_flag.
// Define ALEX_DEDUP_EN to drop words identical to the last one sent.
module axis_alex_scheduler
    import alex_sched_pkg::*;
#(
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned CLK_DIV          = 8,
    parameter int unsigned GUARD_CYCLES     = 16,
    parameter int unsigned HOLDOFF_CYCLES   = 4096
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        alex_flag,
    output logic [3:0]                  alex_data,
    output logic                        busy
);

    localparam int unsigned GW = cnt_width(GUARD_CYCLES - 1);
    localparam int unsigned HW = cnt_width(HOLDOFF_CYCLES);

    alex_state_e                 state_q;
    logic [GW-1:0]               guard_q;
    logic [HW-1:0]               holdoff_q;
    logic [ALEX_WORD_BITS-1:0]   shreg_q;
    logic                        latch_rx_q;
    logic [3:0]                  bit_q;
    logic                        phase_tick;
    logic                        sclk_phase;
    logic                        accept;
    logic                        dedup_hit;

    assign s_axis_tready = (state_q == StIdle) && (holdoff_q == '0);
    assign accept        = s_axis_tvalid && s_axis_tready;

    generate
        if (AXIS_TDATA_WIDTH > ALEX_LATCH_BIT + 1) begin : g_unused_hi
            logic unused_tdata_hi;
            assign unused_tdata_hi = ^s_axis_tdata[AXIS_TDATA_WIDTH-1:ALEX_LATCH_BIT+1];
        end
    endgenerate

`ifdef ALEX_DEDUP_EN
    logic [ALEX_LATCH_BIT:0] last_q;
    logic                    last_valid_q;

    assign dedup_hit = last_valid_q && (s_axis_tdata[ALEX_LATCH_BIT:0] == last_q);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            last_q       <= '0;
            last_valid_q <= 1'b0;
        end else if (accept && !dedup_hit) begin
            last_q       <= s_axis_tdata[ALEX_LATCH_BIT:0];
            last_valid_q <= 1'b1;
        end
    end
`else
    assign dedup_hit = 1'b0;
`endif

    alex_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .enable     ((state_q == StShift) || (state_q == StLatch)),
        .phase_tick (phase_tick),
        .sclk_phase (sclk_phase)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= StIdle;
            guard_q    <= '0;
            holdoff_q  <= HW'(HOLDOFF_CYCLES);
            shreg_q    <= '0;
            latch_rx_q <= 1'b0;
            bit_q      <= '0;
            alex_flag  <= 1'b0;
            alex_data  <= '0;
            busy       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (holdoff_q != '0) holdoff_q <= holdoff_q - 1'b1;
                    if (accept && !dedup_hit) begin
                        state_q    <= StPreGuard;
                        shreg_q    <= s_axis_tdata[ALEX_WORD_BITS-1:0];
                        latch_rx_q <= s_axis_tdata[ALEX_LATCH_BIT];
                        guard_q    <= GW'(GUARD_CYCLES - 1);
                        alex_flag  <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                StPreGuard: begin
                    if (guard_q == '0) begin
                        state_q          <= StShift;
                        bit_q            <= '0;
                        alex_data[SDATA] <= shreg_q[ALEX_WORD_BITS-1];
                    end else begin
                        guard_q <= guard_q - 1'b1;
                    end
                end
                StShift: begin
                    // Low phase ends: raise SCLK. High phase ends: next bit or latch.
                    if (phase_tick) begin
                        if (!sclk_phase) begin
                            alex_data[SCLK] <= 1'b1;
                        end else if (bit_q == 4'(ALEX_WORD_BITS - 1)) begin
                            state_q   <= StLatch;
                            alex_data <= '0;
                            if (latch_rx_q) alex_data[RXL] <= 1'b1;
                            else            alex_data[TXL] <= 1'b1;
                        end else begin
                            bit_q            <= bit_q + 1'b1;
                            shreg_q          <= {shreg_q[ALEX_WORD_BITS-2:0], 1'b0};
                            alex_data[SCLK]  <= 1'b0;
                            alex_data[SDATA] <= shreg_q[ALEX_WORD_BITS-2];
                        end
                    end
                end
                StLatch: begin
                    if (phase_tick) begin
                        state_q   <= StPostGuard;
                        alex_data <= '0;
                        guard_q   <= GW'(GUARD_CYCLES - 1);
                    end
                end
                StPostGuard: begin
                    if (guard_q == '0) begin
                        state_q   <= StIdle;
                        alex_flag <= 1'b0;
                        busy      <= 1'b0;
                        holdoff_q <= HW'(HOLDOFF_CYCLES);
                    end else begin
                        guard_q <= guard_q - 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
